// File: rtl/mul_wr_buffer.sv
// Product buffer between a multiplier and an async FIFO write port: a DEPTH-entry circular queue.
// Optional feature macro MUL_WR_DROP_CNT_EN enables the saturating drop counter on Drop_cnt_o.

module mul_wr_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             Wclk,
    input  logic             Wrst,
    input  logic [WIDTH-1:0] Mul_i,
    input  logic             Mul_valid_i,
    output logic             Mul_ready_o,
    input  logic             Wfull_i,
    output logic [WIDTH-1:0] Wdata_o,
    output logic             Winc_o,
    output logic [1:0]       State_o,
    output logic [7:0]       Drop_cnt_o
);

    // state      | meaning
    // ST_EMPTY   | count == 0, nothing to write downstream
    // ST_PARTIAL | 0 < count < DEPTH, accepting and draining
    // ST_FULL    | count == DEPTH, products offered now are dropped
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    state_t           r_state;

    logic [CW-1:0]    w_count_nxt;
    state_t           w_state_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_ready;

    assign w_ready = (r_count < C_DEPTH);
    assign w_push  = Mul_valid_i & w_ready;
    // Masked during reset so the FIFO never sees a strobe for data being discarded.
    assign w_pop   = (r_count != '0) & ~Wfull_i & ~Wrst;

    assign Mul_ready_o = w_ready;
    assign Winc_o      = w_pop;
    assign Wdata_o     = r_mem[r_rd_ptr];
    assign State_o     = r_state;

    always_comb begin
        w_count_nxt = r_count;
        w_state_nxt = r_state;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
        case (r_state)
            ST_EMPTY: begin
                if (w_push) w_state_nxt = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (w_push && !w_pop && (r_count == (C_DEPTH - C_ONE)))
                    w_state_nxt = ST_FULL;
                else if (w_pop && !w_push && (r_count == C_ONE))
                    w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
                if (w_pop) w_state_nxt = ST_PARTIAL;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge Wclk) begin
        if (Wrst) begin
            r_state  <= ST_EMPTY;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
    end

    // Storage is not reset; entries are only visible once the count covers them.
    always_ff @(posedge Wclk) begin
        if (w_push && !Wrst) r_mem[r_wr_ptr] <= Mul_i;
    end

`ifdef MUL_WR_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge Wclk) begin
        if (Wrst)
            r_drop_cnt <= '0;
        else if (Mul_valid_i && !w_ready && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign Drop_cnt_o = r_drop_cnt;
`else
    assign Drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mul_wr_buffer.sv
// Scoreboard bench for mul_wr_buffer: driver enqueues expected products, negedge monitor checks outputs.
// Reference model is a plain queue of accepted products plus a saturating drop tally.

module tb_mul_wr_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             Wclk = 1'b0;
    logic             Wrst;
    logic [WIDTH-1:0] Mul_i;
    logic             Mul_valid_i;
    logic             Mul_ready_o;
    logic             Wfull_i;
    logic [WIDTH-1:0] Wdata_o;
    logic             Winc_o;
    logic [1:0]       State_o;
    logic [7:0]       Drop_cnt_o;

    always #5 Wclk = ~Wclk;

    mul_wr_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Wclk        (Wclk),
        .Wrst        (Wrst),
        .Mul_i       (Mul_i),
        .Mul_valid_i (Mul_valid_i),
        .Mul_ready_o (Mul_ready_o),
        .Wfull_i     (Wfull_i),
        .Wdata_o     (Wdata_o),
        .Winc_o      (Winc_o),
        .State_o     (State_o),
        .Drop_cnt_o  (Drop_cnt_o)
    );

    logic [WIDTH-1:0] sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  drv_pre_size = 0;
    bit  drv_ready = 1'b1;
    bit  drv_valid = 1'b0;
    bit  drv_rst   = 1'b1;
    bit  drv_wfull = 1'b0;
    bit  mon_en    = 1'b0;
    int  m_drop    = 0;
    bit  exp_winc;
    logic [WIDTH-1:0] exp_data;
    logic [1:0]       exp_state;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs; products the model says are accepted go to the scoreboard now.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit wf, input bit r);
        @(posedge Wclk);
        #1;
        Mul_valid_i  = v;
        Mul_i        = d;
        Wfull_i      = wf;
        Wrst         = r;
        drv_pre_size = sb_q.size();
        drv_ready    = (drv_pre_size < DEPTH);
        drv_valid    = v;
        drv_rst      = r;
        drv_wfull    = wf;
        if (v && !r && drv_ready) sb_q.push_back(d);
    endtask

    task automatic idle(input int n, input bit wf);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, wf, 1'b0);
    endtask

    always @(negedge Wclk) begin
        if (mon_en) begin
            exp_winc  = (drv_pre_size != 0) && !drv_wfull && !drv_rst;
            exp_state = (drv_pre_size == 0) ? 2'b00 : (drv_pre_size == DEPTH) ? 2'b10 : 2'b01;
            chk("ready", {31'd0, Mul_ready_o}, {31'd0, drv_ready});
            chk("winc", {31'd0, Winc_o}, {31'd0, exp_winc});
            chk("state", {30'd0, State_o}, {30'd0, exp_state});
`ifdef MUL_WR_DROP_CNT_EN
            chk("drop_cnt", {24'd0, Drop_cnt_o}, 32'(m_drop));
`else
            chk("drop_cnt", {24'd0, Drop_cnt_o}, 32'd0);
`endif
            if (drv_rst) begin
                sb_q.delete();
                m_drop = 0;
            end else begin
                if (exp_winc) begin
                    exp_data = sb_q.pop_front();
                    chk("wdata", {24'd0, Wdata_o}, {24'd0, exp_data});
                end
                if (drv_valid && !drv_ready && m_drop < 255) m_drop++;
            end
        end
    end

    initial begin
        Wrst        = 1'b1;
        Mul_valid_i = 1'b0;
        Mul_i       = '0;
        Wfull_i     = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1, 1'b0);

        // single product through an empty buffer
        step(1'b1, 8'h0F, 1'b0, 1'b0);
        idle(3, 1'b0);

        // fill while downstream full, then release
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        idle(1, 1'b1);
        idle(5, 1'b0);

        // offers while full are dropped
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hE1, 1'b1, 1'b0);
        idle(6, 1'b0);

        // count held at 2 under continuous push and pop
        step(1'b1, 8'h21, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        idle(4, 1'b0);

        // one-cycle release while full: pop only, ready returns next cycle
        for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b1, 1'b0);
        idle(6, 1'b0);

        // reset with three products buffered
        for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(4, 1'b0);

        // drop counter saturation
        for (int i = 0; i < 4; i++) step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 262; i++) step(1'b1, 8'hEE, 1'b1, 1'b0);
        idle(6, 1'b0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0, ($urandom % 250) == 0);

        idle(8, 1'b0);
        @(negedge Wclk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_wr_buffer.md
MUL_WR_BUFFER -- requirements
Module: mul_wr_buffer

Interface
REQ-001 Parameter WIDTH, default 8, product/data width in bits.
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, at least 2.
REQ-003 Port Wclk, input, 1, write-domain clock; all state updates on its rising edge.
REQ-004 Port Wrst, input, 1, reset; synchronous and active-high.
REQ-005 Port Mul_i, input, WIDTH, product from the upstream multiplier.
REQ-006 Port Mul_valid_i, input, 1, Mul_i holds a product to be enqueued this cycle.
REQ-007 Port Mul_ready_o, output, 1, buffer can accept a product this cycle.
REQ-008 Port Wfull_i, input, 1, downstream FIFO write side is full.
REQ-009 Port Wdata_o, output, WIDTH, data presented to the FIFO write port.
REQ-010 Port Winc_o, output, 1, FIFO write strobe; Wdata_o is written at the Wclk edge where Winc_o=1.
REQ-011 Port State_o, output, 2, buffer state: 00 EMPTY, 01 PARTIAL, 10 FULL; 11 is never driven.
REQ-012 Port Drop_cnt_o, output, 8, count of products offered while not ready.

Function
REQ-013 The buffer SHALL be a circular queue of DEPTH x WIDTH with read pointer, write pointer and occupancy count; pointers wrap modulo DEPTH.
REQ-014 Push SHALL occur at an edge where Mul_valid_i=1 and Mul_ready_o=1; Mul_i is stored at the write pointer.
REQ-015 Mul_ready_o SHALL be 1 exactly when the count is less than DEPTH; it is combinational from registered state and does not depend on Wfull_i.
REQ-016 Winc_o SHALL equal (count != 0) AND NOT Wfull_i, combinationally.
REQ-017 Wdata_o SHALL always show the entry at the read pointer; its value is don't-care when EMPTY.
REQ-018 Pop SHALL occur at an edge where Winc_o=1.
REQ-019 Latency SHALL be 1 cycle: a product pushed into an EMPTY buffer appears on Wdata_o with Winc_o=1 in the next cycle when Wfull_i=0.
REQ-020 On simultaneous push and pop, the count SHALL stay unchanged and both pointers SHALL advance.
REQ-021 In FULL state a push is not possible, even in a cycle with a concurrent pop (no bypass); ready rises in the cycle after the pop.
REQ-022 While Wfull_i=1, there SHALL be no pop; contents and order are preserved, and pushes continue until FULL.
REQ-023 Order SHALL be strict FIFO; no product is duplicated or reordered.
REQ-024 State transitions SHALL follow the count: EMPTY when 0, FULL when DEPTH, PARTIAL otherwise. EMPTY goes to PARTIAL on push only. PARTIAL goes to FULL on push-only at count DEPTH-1. PARTIAL goes to EMPTY on pop-only at count 1. FULL goes to PARTIAL on pop.
REQ-025 A product offered with Mul_valid_i=1 while Mul_ready_o=0 SHALL be discarded and does not stall upstream.
REQ-026 Drop_cnt_o SHALL saturate at 255.

Reset
REQ-027 When Wrst=1 at an edge, count, pointers and Drop_cnt_o SHALL clear to 0 and State_o SHALL become EMPTY; buffer contents need not clear.
REQ-028 After reset, the outputs SHALL be Mul_ready_o=1, Winc_o=0, State_o=00 and Drop_cnt_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered products, and no Winc_o pulse is generated in the reset cycle or the cycle after.
REQ-030 Wrst SHALL take priority over a push or pop in the same cycle.

Configuration
REQ-031 Macro MUL_WR_DROP_CNT_EN defined: Drop_cnt_o SHALL increment by 1 at each edge with Mul_valid_i=1 and Mul_ready_o=0, saturating at 255.
REQ-032 Macro MUL_WR_DROP_CNT_EN undefined: Drop_cnt_o SHALL be tied to 0 and no counter register is built; all other behaviour is identical.

Verification
REQ-033 Reset, then push 0x0F with Wfull_i=0 -> the next cycle gives Wdata_o=0x0F and Winc_o=1, and the cycle after gives State_o=00.
REQ-034 Hold Wfull_i=1 and push 0x01, 0x02, 0x03, 0x04 -> State_o=10 and Mul_ready_o=0. Release Wfull_i -> Winc_o=1 for 4 cycles with Wdata_o 0x01, 0x02, 0x03, 0x04.
REQ-035 When FULL with Wfull_i=1, offer 0xE1 for 3 cycles -> 0xE1 is never written. Drop_cnt_o=3 with the macro defined, and 0 without it.
REQ-036 When PARTIAL with count 2 and Wfull_i=0, push every cycle for 10 cycles -> the count stays 2 and output order matches input order.
REQ-037 When FULL, pulse Wfull_i low for 1 cycle while Mul_valid_i=1 -> exactly one pop. Ready is 0 in the pop cycle and 1 the next cycle, and no product is pushed in the pop cycle.
REQ-038 Assert Wrst with count 3 -> State_o=00 and Winc_o=0 after the edge, and the old data never appears with Winc_o=1.
